// File: rtl/tausworthe_urng_mc.sv
// Multi-channel combined Tausworthe (taus88) uniform RNG with per-channel seed load,
// post-seed warm-up discard and a ready/valid output register.
module tausworthe_urng_mc #(
    parameter int unsigned NUM_CH        = 2,
    parameter int unsigned OUT_W         = 32,
    parameter int unsigned WARMUP_CYCLES = 8,
    parameter logic [31:0] SEED0         = 32'h0f0f0f0f,
    parameter logic [31:0] SEED1         = 32'h0c0c0c0c,
    parameter logic [31:0] SEED2         = 32'h00ff00ff,
    localparam int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      seed_load,
    input  logic [CH_W-1:0]           seed_ch,
    input  logic [95:0]               seed_data,
    output logic                      seed_err,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_CH*OUT_W-1:0]   out_data
);

    localparam int unsigned CNT_W = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;

    typedef enum logic {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } fsm_t;

    // One taus88 step on a packed {S2,S1,S0} state.
    function automatic logic [95:0] taus_step(input logic [95:0] s);
        logic [31:0] s0, s1, s2, b;
        s0 = s[31:0];
        s1 = s[63:32];
        s2 = s[95:64];
        b  = ((s0 << 13) ^ s0) >> 19;
        s0 = ((s0 & 32'hFFFF_FFFE) << 12) ^ b;
        b  = ((s1 << 2) ^ s1) >> 25;
        s1 = ((s1 & 32'hFFFF_FFF8) << 4) ^ b;
        b  = ((s2 << 3) ^ s2) >> 11;
        s2 = ((s2 & 32'hFFFF_FFF0) << 17) ^ b;
        return {s2, s1, s0};
    endfunction

    // Forces each component above its degenerate range so the generator cannot lock up.
    function automatic logic [95:0] sanitise(input logic [95:0] s);
        logic [31:0] s0, s1, s2;
        s0 = s[31:0];
        s1 = s[63:32];
        s2 = s[95:64];
        if (s0 < 32'd2)  s0 = s0 | 32'd2;
        if (s1 < 32'd8)  s1 = s1 | 32'd8;
        if (s2 < 32'd16) s2 = s2 | 32'd16;
        return {s2, s1, s0};
    endfunction

    function automatic logic [OUT_W-1:0] sample(input logic [95:0] s);
        logic [31:0] w;
        w = s[31:0] ^ s[63:32] ^ s[95:64];
        return w[31 -: OUT_W];
    endfunction

    function automatic logic [95:0] reset_seed(input int unsigned c);
        logic [31:0] k;
        k = 32'(c) * 32'h9E3779B9;
        return sanitise({SEED2 ^ k, SEED1 ^ k, SEED0 ^ k});
    endfunction

    fsm_t                        fsm_q, fsm_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [NUM_CH-1:0][95:0]     st_q, st_d;
    logic                        valid_q, valid_d;
    logic [NUM_CH*OUT_W-1:0]     data_q, data_d;
    logic                        err_q, err_d;
    logic                        busy_q, busy_d;
    logic                        seed_ok;
    logic                        fire;

    assign seed_ok = (32'(seed_ch) < NUM_CH);
    assign fire    = enable & (~valid_q | out_ready);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q   <= (WARMUP_CYCLES == 0) ? ST_RUN : ST_WARMUP;
            cnt_q   <= CNT_W'(WARMUP_CYCLES);
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                st_q[c] <= reset_seed(c);
            end
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= (WARMUP_CYCLES != 0);
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            st_q    <= st_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // A valid seed load overrides stepping and firing; all other channels hold that cycle.
    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        st_d    = st_q;
        valid_d = valid_q;
        data_d  = data_q;
        err_d   = 1'b0;

        if (seed_load && seed_ok) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (CH_W'(c) == seed_ch) begin
                    st_d[c] = sanitise(seed_data);
                end
            end
            valid_d = 1'b0;
            cnt_d   = CNT_W'(WARMUP_CYCLES);
            fsm_d   = (WARMUP_CYCLES == 0) ? ST_RUN : ST_WARMUP;
        end else begin
            err_d = seed_load;
            case (fsm_q)
                ST_WARMUP: begin
                    if (enable) begin
                        for (int unsigned c = 0; c < NUM_CH; c++) begin
                            st_d[c] = taus_step(st_q[c]);
                        end
                        cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            fsm_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (fire) begin
                        for (int unsigned c = 0; c < NUM_CH; c++) begin
                            data_d[c*OUT_W +: OUT_W] = sample(st_q[c]);
                            st_d[c]                  = taus_step(st_q[c]);
                        end
                        valid_d = 1'b1;
                    end else if (out_ready && valid_q) begin
                        valid_d = 1'b0;
                    end
                end
                default: fsm_d = ST_RUN;
            endcase
        end

        busy_d = (fsm_d == ST_WARMUP);
    end

    assign seed_err  = err_q;
    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: tb/tb_tausworthe_urng_mc.sv
// Scoreboard bench: a 3-channel, 24-bit, 4-step warm-up generator checked against a taus88
// model, plus a 2-channel no-warm-up instance checked against known sample values.
module tb_tausworthe_urng_mc;

    localparam int M_CH = 3;
    localparam int M_W  = 24;
    localparam int M_WU = 4;

    logic               clock;
    logic               reset_n;
    logic               enable;
    logic               seed_load;
    logic [1:0]         seed_ch;
    logic [95:0]        seed_data;
    logic               seed_err;
    logic               busy;
    logic               out_valid;
    logic               out_ready;
    logic [M_CH*M_W-1:0] out_data;

    logic               z_seed_load;
    logic [0:0]         z_seed_ch;
    logic [95:0]        z_seed_data;
    logic               z_seed_err;
    logic               z_busy;
    logic               z_out_valid;
    logic [63:0]        z_out_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [95:0]        m_st [M_CH];
    int                 m_cnt;
    logic               m_valid;
    logic               m_err;
    logic [M_CH*M_W-1:0] sb [$];

    tausworthe_urng_mc #(.NUM_CH(M_CH), .OUT_W(M_W), .WARMUP_CYCLES(M_WU)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .seed_load(seed_load),
        .seed_ch(seed_ch), .seed_data(seed_data), .seed_err(seed_err), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    tausworthe_urng_mc #(.NUM_CH(2), .OUT_W(32), .WARMUP_CYCLES(0)) dut_z (
        .clock(clock), .reset_n(reset_n), .enable(1'b1), .seed_load(z_seed_load),
        .seed_ch(z_seed_ch), .seed_data(z_seed_data), .seed_err(z_seed_err), .busy(z_busy),
        .out_valid(z_out_valid), .out_ready(1'b1), .out_data(z_out_data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] comp(input logic [31:0] s, input int a, input int sh,
                                         input int c, input logic [31:0] m);
        logic [31:0] b;
        b = ((s << a) ^ s) >> sh;
        return ((s & m) << c) ^ b;
    endfunction

    function automatic logic [95:0] m_step(input logic [95:0] x);
        return {comp(x[95:64], 3, 11, 17, 32'hFFFFFFF0),
                comp(x[63:32], 2, 25, 4, 32'hFFFFFFF8),
                comp(x[31:0], 13, 19, 12, 32'hFFFFFFFE)};
    endfunction

    function automatic logic [95:0] m_clean(input logic [95:0] x);
        logic [95:0] y;
        y = x;
        if (y[31:0] < 2)   y[31:0]  = y[31:0] | 32'd2;
        if (y[63:32] < 8)  y[63:32] = y[63:32] | 32'd8;
        if (y[95:64] < 16) y[95:64] = y[95:64] | 32'd16;
        return y;
    endfunction

    function automatic logic [31:0] m_word(input logic [95:0] x);
        return x[31:0] ^ x[63:32] ^ x[95:64];
    endfunction

    function automatic logic [M_W-1:0] m_samp(input logic [95:0] x);
        logic [31:0] w;
        w = m_word(x);
        return w[31:32-M_W];
    endfunction

    function automatic logic [95:0] m_rst(input int c);
        logic [31:0] k;
        k = 32'(c) * 32'h9E3779B9;
        return m_clean({32'h00ff00ff ^ k, 32'h0c0c0c0c ^ k, 32'h0f0f0f0f ^ k});
    endfunction

    task automatic model_reset();
        for (int c = 0; c < M_CH; c++) m_st[c] = m_rst(c);
        m_cnt   = M_WU;
        m_valid = 1'b0;
        m_err   = 1'b0;
        sb.delete();
    endtask

    // Drives one cycle from a negedge, checks outputs, advances the model, waits for the next negedge.
    task automatic drive_cycle(input logic en, input logic rdy, input logic ld,
                               input logic [1:0] ch, input logic [95:0] d);
        logic [M_CH*M_W-1:0] e;
        enable    = en;
        out_ready = rdy;
        seed_load = ld;
        seed_ch   = ch;
        seed_data = d;
        #1;
        chk("valid", 96'(out_valid), 96'(m_valid));
        chk("busy", 96'(busy), 96'(m_cnt > 0));
        chk("seed_err", 96'(seed_err), 96'(m_err));
        if (m_valid) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 96'(1), 96'(0));
            end else begin
                chk("data", 96'(out_data), 96'(sb[0]));
                if (rdy) void'(sb.pop_front());
            end
        end
        m_err = 1'b0;
        if (ld && ch < M_CH) begin
            m_st[ch] = m_clean(d);
            if (m_valid && !rdy && sb.size() > 0) void'(sb.pop_front());
            m_valid = 1'b0;
            m_cnt   = M_WU;
        end else begin
            m_err = ld;
            if (m_cnt > 0) begin
                if (en) begin
                    for (int c = 0; c < M_CH; c++) m_st[c] = m_step(m_st[c]);
                    m_cnt--;
                end
            end else if (en && (!m_valid || rdy)) begin
                for (int c = 0; c < M_CH; c++) begin
                    e[c*M_W +: M_W] = m_samp(m_st[c]);
                    m_st[c] = m_step(m_st[c]);
                end
                sb.push_back(e);
                m_valid = 1'b1;
            end else if (rdy && m_valid) begin
                m_valid = 1'b0;
            end
        end
        @(negedge clock);
    endtask

    logic [95:0] zm, z1, rd;

    initial begin
        reset_n     = 1'b0;
        enable      = 1'b0;
        out_ready   = 1'b0;
        seed_load   = 1'b0;
        seed_ch     = '0;
        seed_data   = '0;
        z_seed_load = 1'b0;
        z_seed_ch   = '0;
        z_seed_data = '0;
        repeat (3) @(negedge clock);

        chk("rst_valid", 96'(out_valid), 96'(0));
        chk("rst_data", 96'(out_data), 96'(0));
        chk("rst_busy", 96'(busy), 96'(1));
        chk("rst_err", 96'(seed_err), 96'(0));
        chk("z_rst_busy", 96'(z_busy), 96'(0));
        chk("z_rst_valid", 96'(z_out_valid), 96'(0));
        reset_n = 1'b1;
        model_reset();

        // No-warm-up instance: known first sample, zero-seed load on ch1, ch0 continuity.
        zm = m_rst(0);
        drive_cycle(1'b0, 1'b1, 1'b0, 2'd0, 96'd0);
        chk("z_valid0", 96'(z_out_valid), 96'(1));
        chk("z_first", 96'(z_out_data[31:0]), 96'(32'h03fc03fc));
        zm = m_step(zm);
        z_seed_load = 1'b1;
        z_seed_ch   = 1'b1;
        z_seed_data = 96'd0;
        drive_cycle(1'b0, 1'b1, 1'b0, 2'd0, 96'd0);
        z_seed_load = 1'b0;
        chk("z_drop", 96'(z_out_valid), 96'(0));
        drive_cycle(1'b0, 1'b1, 1'b0, 2'd0, 96'd0);
        chk("z_ch1_zero", 96'(z_out_data[63:32]), 96'(32'h0000001a));
        chk("z_ch0_cont1", 96'(z_out_data[31:0]), 96'(m_word(zm)));
        zm = m_step(zm);
        z1 = m_step({32'd16, 32'd8, 32'd2});
        drive_cycle(1'b0, 1'b1, 1'b0, 2'd0, 96'd0);
        chk("z_ch1_next", 96'(z_out_data[63:32]), 96'(m_word(z1)));
        chk("z_ch0_cont2", 96'(z_out_data[31:0]), 96'(m_word(zm)));

        // Warm-up then streaming, then a 10-cycle stall and release.
        repeat (40) drive_cycle(1'b1, 1'b1, 1'b0, 2'd0, 96'd0);
        repeat (10) drive_cycle(1'b1, 1'b0, 1'b0, 2'd0, 96'd0);
        repeat (10) drive_cycle(1'b1, 1'b1, 1'b0, 2'd0, 96'd0);

        // Out-of-range channel while stalled and while running.
        drive_cycle(1'b1, 1'b0, 1'b1, 2'd3, {$urandom, $urandom, $urandom});
        drive_cycle(1'b1, 1'b0, 1'b0, 2'd0, 96'd0);
        drive_cycle(1'b1, 1'b1, 1'b1, 2'd3, {$urandom, $urandom, $urandom});
        repeat (5) drive_cycle(1'b1, 1'b1, 1'b0, 2'd0, 96'd0);

        // Load coincident with fire, warm-up with enable toggling.
        drive_cycle(1'b1, 1'b1, 1'b1, 2'd1, 96'd0);
        for (int i = 0; i < 12; i++) drive_cycle(1'(i % 2), 1'b1, 1'b0, 2'd0, 96'd0);
        repeat (10) drive_cycle(1'b1, 1'b1, 1'b0, 2'd0, 96'd0);

        // Load with enable low, then a restart during warm-up.
        drive_cycle(1'b0, 1'b1, 1'b1, 2'd2, {$urandom, $urandom, $urandom});
        repeat (3) drive_cycle(1'b0, 1'b1, 1'b0, 2'd0, 96'd0);
        repeat (2) drive_cycle(1'b1, 1'b1, 1'b0, 2'd0, 96'd0);
        drive_cycle(1'b1, 1'b1, 1'b1, 2'd0, {$urandom, $urandom, $urandom});
        repeat (10) drive_cycle(1'b1, 1'b1, 1'b0, 2'd0, 96'd0);

        // Random traffic with occasional seed loads, including degenerate seeds.
        for (int i = 0; i < 10000; i++) begin
            rd = {$urandom, $urandom, $urandom};
            if ($urandom_range(0, 3) == 0)
                rd = {32'($urandom_range(0, 20)), 32'($urandom_range(0, 10)), 32'($urandom_range(0, 3))};
            drive_cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                        $urandom_range(0, 199) == 0, 2'($urandom_range(0, 3)), rd);
        end

        // Asynchronous reset mid-stream.
        repeat (10) drive_cycle(1'b1, 1'b1, 1'b0, 2'd0, 96'd0);
        chk("pre_rst_valid", 96'(out_valid), 96'(1));
        #2 reset_n = 1'b0;
        #1;
        chk("async_valid", 96'(out_valid), 96'(0));
        chk("async_data", 96'(out_data), 96'(0));
        chk("async_busy", 96'(busy), 96'(1));
        chk("z_async_valid", 96'(z_out_valid), 96'(0));
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        drive_cycle(1'b1, 1'b1, 1'b0, 2'd0, 96'd0);
        chk("z_restart", 96'(z_out_data[31:0]), 96'(32'h03fc03fc));
        repeat (30) drive_cycle(1'b1, 1'b1, 1'b0, 2'd0, 96'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
